fir_out_multi_pio: RTL

FIR_OUT_MULTI_PIO -- requirements
Module: fir_out_multi_pio

---
 rtl/fir_out_pio_pkg.sv | 30 +++
 rtl/fir_out_chan_reg.sv | 57 +++++
 rtl/fir_out_multi_pio.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_out_pio_pkg.sv
// -----------------------------------------------------------------------------
// fir_out_pio_pkg
// Shared definitions for the multi-channel FIR output PIO.
//   - Offsets of the CTRL/STATUS registers relative to the channel count
//   - Bit positions inside CTRL and STATUS
//   - Width of the commit counter
//   - State encoding of the output-frame control
// -----------------------------------------------------------------------------
package fir_out_pio_pkg;

   // CTRL sits at NUM_CH + CTRL_OFS and STATUS sits at NUM_CH + STATUS_OFS.
   localparam int CTRL_OFS         = 0;
   localparam int STATUS_OFS       = 1;

   localparam int CTRL_COMMIT_BIT  = 0;
   localparam int CTRL_CLR_OVF_BIT = 1;

   localparam int STATUS_VALID_BIT = 0;
   localparam int STATUS_OVF_BIT   = 1;
   localparam int STATUS_CNT_LSB   = 8;

   localparam int COMMIT_CNT_W     = 8;

   // IDLE: no frame waiting for the consumer; PENDING: out_valid is high.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } ctrl_state_e;

endpackage : fir_out_pio_pkg

// File: rtl/fir_out_chan_reg.sv
// -----------------------------------------------------------------------------
// fir_out_chan_reg
// One output channel: a shadow register loaded by the bus and an output
// register that takes the shadow value when a commit occurs.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset, clears both registers
//   load_en    - load load_data into the shadow register
//   load_data  - new shadow value
//   commit_en  - copy the shadow register into the output register
//   shadow     - current shadow value (for bus read-back)
//   out_val    - committed output value
// -----------------------------------------------------------------------------
module fir_out_chan_reg
   import fir_out_pio_pkg::*;
#(
   parameter int DATA_W = 31
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_en,
   input  logic [DATA_W-1:0] load_data,
   input  logic              commit_en,
   output logic [DATA_W-1:0] shadow,
   output logic [DATA_W-1:0] out_val
);

   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] out_q, out_d;

   // The commit copies shadow_q, the pre-edge value, so a shadow write landing
   // on the same edge as a commit only shows up in the following frame.
   always_comb begin
      shadow_d = shadow_q;
      out_d    = out_q;
      if (load_en) begin
         shadow_d = load_data;
      end
      if (commit_en) begin
         out_d = shadow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow_q <= '0;
         out_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign shadow  = shadow_q;
   assign out_val = out_q;

endmodule : fir_out_chan_reg

// File: rtl/fir_out_multi_pio.sv
// -----------------------------------------------------------------------------
// fir_out_multi_pio
// Avalon-MM slave that collects NUM_CH channel values in shadow registers and
// publishes them atomically as one frame on out_port when software commits.
// A valid/ready handshake tells the consumer a new frame is waiting; a sticky
// overflow flag records frames replaced before the consumer took them.
// Register map (word addresses):
//   0..NUM_CH-1 : channel shadows (R/W)
//   NUM_CH      : CTRL   (W) bit0 COMMIT, bit1 CLR_OVF; reads 0
//   NUM_CH+1    : STATUS (R) bit0 out_valid, bit1 ovf, bits[15:8] commit_cnt
//   others      : read 0, writes ignored
// Ports:
//   clk, reset_n                      - clock, synchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata               - Avalon-MM slave, zero read latency
//   out_port                          - committed frame, channel k at [k*DATA_W +: DATA_W]
//   out_valid, out_ready              - frame handshake to the consumer
// The address space must hold the map: 2**ADDR_W >= NUM_CH + 2.
// -----------------------------------------------------------------------------
module fir_out_multi_pio
   import fir_out_pio_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 31,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     chipselect,
   input  logic                     write_n,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic [NUM_CH*DATA_W-1:0] out_port,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int CTRL_ADDR   = NUM_CH + CTRL_OFS;
   localparam int STATUS_ADDR = NUM_CH + STATUS_OFS;

   logic wr_en;
   logic ctrl_wr;
   logic commit;
   logic clr_ovf;
   logic unused_wdata;

   assign wr_en   = chipselect && !write_n;
   assign ctrl_wr = wr_en && (address == ADDR_W'(CTRL_ADDR));
   assign commit  = ctrl_wr && writedata[CTRL_COMMIT_BIT];
   assign clr_ovf = ctrl_wr && writedata[CTRL_CLR_OVF_BIT];

   // Upper write-data bits beyond the channel width carry no meaning.
   assign unused_wdata = ^writedata;

   logic [DATA_W-1:0] shadow_val [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic load_en;
      assign load_en = wr_en && (address == ADDR_W'(k));

      fir_out_chan_reg #(
         .DATA_W (DATA_W)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .load_en   (load_en),
         .load_data (writedata[DATA_W-1:0]),
         .commit_en (commit),
         .shadow    (shadow_val[k]),
         .out_val   (out_port[k*DATA_W +: DATA_W])
      );
   end

   ctrl_state_e             state_q, state_d;
   logic                    ovf_q, ovf_d;
   logic [COMMIT_CNT_W-1:0] cnt_q, cnt_d;

   // A commit always leaves a frame pending, even if the consumer takes the
   // previous one on the same edge. Overflow is only a commit that replaces a
   // frame nobody accepted; it is applied after CLR_OVF so it wins.
   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (commit) begin
         state_d = ST_PENDING;
         cnt_d   = cnt_q + COMMIT_CNT_W'(1);
      end else if ((state_q == ST_PENDING) && out_ready) begin
         state_d = ST_IDLE;
      end
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (commit && (state_q == ST_PENDING) && !out_ready) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q == ST_PENDING);

   always_comb begin
      readdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (address == ADDR_W'(k)) begin
            readdata = 32'(shadow_val[k]);
         end
      end
      if (address == ADDR_W'(STATUS_ADDR)) begin
         readdata[STATUS_VALID_BIT]                   = out_valid;
         readdata[STATUS_OVF_BIT]                     = ovf_q;
         readdata[STATUS_CNT_LSB +: COMMIT_CNT_W]     = cnt_q;
      end
   end

endmodule : fir_out_multi_pio
